// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: combinational fetch lookup,
// EX-stage training, mispredict/redirect generation and prediction statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_is_jump,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [CNT_W-1:0]  cnt_d    [ENTRIES];
    logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             upd_hit;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Fetch-side lookup; reads pre-update contents (no write-through).
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && cnt_q[if_idx][CNT_W-1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + ADDR_W'(4);
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

    // Training and statistics next-state.
    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd_valid) begin
            br_cnt_d = br_cnt_q + STAT_W'(1);
            if (mispredict) begin
                miss_cnt_d = miss_cnt_q + STAT_W'(1);
            end
            if (upd_hit) begin
                if (upd_is_jump) begin
                    cnt_d[upd_idx]    = CNT_MAX;
                    target_d[upd_idx] = upd_target;
                end else if (upd_taken) begin
                    if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
                    end
                    target_d[upd_idx] = upd_target;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever currently occupies the slot.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = upd_is_jump ? CNT_MAX : CNT_WT;
            end
        end
        if (clr_stats) begin
            br_cnt_d   = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
